// File: rtl/lc3b_types.sv
// Shared LC-3b memory types and the arbiter state encoding.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [2:0] {
    IDLE,
    BUSY_A,
    BUSY_B,
    DONE_A,
    DONE_B
  } arb_state_t;

endpackage

// File: rtl/mem_arb_req_reg.sv
// Captured downstream request (address, write data, mask, op).
// A single copy is shared by both ports because only one transaction is ever in flight.
module mem_arb_req_reg
  import lc3b_types::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] addr_d,
  input  logic [WIDTH-1:0] wdata_d,
  input  lc3b_mem_wmask    mask_d,
  input  logic             write_d,
  output logic [WIDTH-1:0] addr_q,
  output logic [WIDTH-1:0] wdata_q,
  output lc3b_mem_wmask    mask_q,
  output logic             write_q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      write_q <= 1'b0;
    end else if (load) begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      write_q <= write_d;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch A, data B) arbiter onto one word-wide downstream memory,
// with B-priority limited by a starvation counter that eventually forces A.
module mem_arbiter
  import lc3b_types::*;
#(
  parameter int WIDTH        = 16,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] mem_addr1,
  input  logic             mem_read1,
  output logic [WIDTH-1:0] mem_rdata1,
  output logic             resp_a,
  input  logic [WIDTH-1:0] mem_addr2,
  input  logic             mem_read2,
  input  logic             mem_write2,
  input  logic [WIDTH-1:0] mem_wdata2,
  input  logic [1:0]       mem_byte_enable2,
  output logic [WIDTH-1:0] mem_rdata2,
  output logic             resp_b,
  output logic [WIDTH-1:0] pmem_addr,
  output logic             pmem_read,
  output logic             pmem_write,
  output logic [WIDTH-1:0] pmem_wdata,
  output logic [1:0]       pmem_wmask,
  input  logic [WIDTH-1:0] pmem_rdata,
  input  logic             pmem_resp,
  output logic             protocol_err
);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;

  logic             req_a, req_b, starved, grant_a, grant_b, load, busy;
  logic [WIDTH-1:0] ld_addr, ld_wdata;
  lc3b_mem_wmask    ld_mask;
  logic             ld_write;
  logic [WIDTH-1:0] q_addr, q_wdata;
  lc3b_mem_wmask    q_mask;
  logic             q_write;

  assign req_a   = mem_read1;
  assign req_b   = mem_read2 | mem_write2;
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));
  assign grant_b = (state == IDLE) && req_b && !(req_a && starved);
  assign grant_a = (state == IDLE) && req_a && !grant_b;
  assign load    = grant_a | grant_b;
  assign busy    = (state == BUSY_A) || (state == BUSY_B);

  // A read+write collision on port B is resolved as a write.
  assign ld_addr  = grant_b ? mem_addr2 : mem_addr1;
  assign ld_wdata = grant_b ? mem_wdata2 : '0;
  assign ld_mask  = grant_b ? mem_byte_enable2 : '0;
  assign ld_write = grant_b & mem_write2;

  mem_arb_req_reg #(.WIDTH(WIDTH)) u_req_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .addr_d  (ld_addr),
    .wdata_d (ld_wdata),
    .mask_d  (ld_mask),
    .write_d (ld_write),
    .addr_q  (q_addr),
    .wdata_q (q_wdata),
    .mask_q  (q_mask),
    .write_q (q_write)
  );

  assign pmem_addr  = busy ? q_addr  : '0;
  assign pmem_wdata = busy ? q_wdata : '0;
  assign pmem_wmask = busy ? q_mask  : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      pmem_read  <= 1'b0;
      pmem_write <= 1'b0;
      resp_a     <= 1'b0;
      resp_b     <= 1'b0;
      mem_rdata1 <= '0;
      mem_rdata2 <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (grant_b) begin
            state      <= BUSY_B;
            pmem_read  <= ~mem_write2;
            pmem_write <= mem_write2;
            if (!req_a)
              starve_cnt <= '0;
            else if (!starved)
              starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (grant_a) begin
            state      <= BUSY_A;
            pmem_read  <= 1'b1;
            starve_cnt <= '0;
          end
        end
        BUSY_A: begin
          if (pmem_resp) begin
            state      <= DONE_A;
            pmem_read  <= 1'b0;
            resp_a     <= 1'b1;
            mem_rdata1 <= pmem_rdata;
          end
        end
        BUSY_B: begin
          if (pmem_resp) begin
            state      <= DONE_B;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
            resp_b     <= 1'b1;
            if (!q_write)
              mem_rdata2 <= pmem_rdata;
          end
        end
        DONE_A: begin
          state  <= IDLE;
          resp_a <= 1'b0;
        end
        DONE_B: begin
          state  <= IDLE;
          resp_b <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      protocol_err <= 1'b0;
    else if (mem_read2 && mem_write2)
      protocol_err <= 1'b1;
  end

endmodule
